loop_control_sequencer: RTL and testbench

//  Start-up/shutdown sequencer for the 5V control-loop brick cluster.

---
 rtl/loop_control_sequencer.sv | 157 +++++++++++++++
 tb/tb_loop_control_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/loop_control_sequencer.sv
// Start-up/shutdown sequencer for the 5V control-loop brick cluster: precharge, loop enable, soft-start
// ramp of the reference DAC code, regulation tracking and fault shutdown. Define LOOP_SEQ_RETRY_EN for auto-retry.
module loop_control_sequencer #(
  parameter int REF_W      = 8,
  parameter int PRECHG_CYC = 16,
  parameter int STEP_CYC   = 4,
`ifdef LOOP_SEQ_RETRY_EN
  parameter int RETRY_CYC  = 255,
`endif
  parameter int PG_FILT    = 3
) (
  input  logic             CELCLK,
  input  logic             CELRSTN,
  input  logic             en,
  input  logic [REF_W-1:0] ref_tgt,
  input  logic             ovp,
  input  logic             pgood,
  output logic             prechg,
  output logic             loop_en,
  output logic [REF_W-1:0] ref_dac,
  output logic             ready,
  output logic             fault,
  output logic [2:0]       state
);

`ifdef LOOP_SEQ_RETRY_EN
  localparam int CNT_MAX = (RETRY_CYC > PRECHG_CYC) ? RETRY_CYC : PRECHG_CYC;
`else
  localparam int CNT_MAX = PRECHG_CYC;
`endif
  localparam int CNT_W  = $clog2(CNT_MAX + 1);
  localparam int STEP_W = $clog2(STEP_CYC + 1);
  localparam int PG_W   = $clog2(PG_FILT + 1);

  localparam logic [CNT_W-1:0]  PRECHG_LAST = CNT_W'(PRECHG_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(STEP_CYC - 1);
  localparam logic [PG_W-1:0]   PG_LAST     = PG_W'(PG_FILT - 1);
`ifdef LOOP_SEQ_RETRY_EN
  localparam logic [CNT_W-1:0]  RETRY_LAST  = CNT_W'(RETRY_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRECHG = 3'd1,
    S_RAMP   = 3'd2,
    S_REG    = 3'd3,
    S_FAULT  = 3'd4,
    S_COOL   = 3'd5
  } state_t;

  state_t            cur_state, nxt_state;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [STEP_W-1:0] step_cnt, step_nxt;
  logic [PG_W-1:0]   pg_cnt, pg_nxt;
  logic [REF_W-1:0]  dac_nxt;
  logic              prechg_nxt, loop_en_nxt, ready_nxt, fault_nxt;

  // One LSB toward the target; stepping only while unequal keeps the code inside 0..2^REF_W-1.
  function automatic logic [REF_W-1:0] step_toward(input logic [REF_W-1:0] cur,
                                                   input logic [REF_W-1:0] tgt);
    if (cur < tgt) return cur + 1'b1;
    if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction

  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = cnt;
    step_nxt  = step_cnt;
    pg_nxt    = '0;
    dac_nxt   = ref_dac;
    case (cur_state)
      S_IDLE: if (en) nxt_state = S_PRECHG;
      S_PRECHG: begin
        if (ovp)                       nxt_state = S_FAULT;
        else if (!en)                  nxt_state = S_IDLE;
        else if (cnt == PRECHG_LAST)   nxt_state = S_RAMP;
        else                           cnt_nxt   = cnt + 1'b1;
      end
      S_RAMP, S_REG: begin
        if (ovp)                       nxt_state = S_FAULT;
        else if (!en)                  nxt_state = S_IDLE;
        else if (cur_state == S_REG && !pgood && pg_cnt == PG_LAST)
                                       nxt_state = S_FAULT;
        else begin
          // Step timer idles at zero while on target so a new target always waits a full STEP_CYC.
          if (ref_dac == ref_tgt)
            step_nxt = '0;
          else if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            dac_nxt  = step_toward(ref_dac, ref_tgt);
          end else
            step_nxt = step_cnt + 1'b1;
          if (cur_state == S_REG) begin
            if (!pgood) pg_nxt = pg_cnt + 1'b1;
          end else if (ref_dac == ref_tgt && pgood)
            nxt_state = S_REG;
        end
      end
`ifdef LOOP_SEQ_RETRY_EN
      S_FAULT: nxt_state = en ? S_COOL : S_IDLE;
      S_COOL: begin
        if (!en)                       nxt_state = S_IDLE;
        else if (ovp)                  cnt_nxt   = '0;
        else if (cnt == RETRY_LAST)    nxt_state = S_PRECHG;
        else                           cnt_nxt   = cnt + 1'b1;
      end
`else
      S_FAULT: if (!en) nxt_state = S_IDLE;
`endif
      default: nxt_state = S_IDLE;
    endcase

    if (nxt_state != cur_state) begin
      cnt_nxt  = '0;
      step_nxt = '0;
      pg_nxt   = '0;
    end
    if (!(cur_state inside {S_RAMP, S_REG}) || !(nxt_state inside {S_RAMP, S_REG}))
      dac_nxt = '0;

    prechg_nxt  = (nxt_state == S_PRECHG);
    loop_en_nxt = (nxt_state inside {S_RAMP, S_REG});
    ready_nxt   = (nxt_state == S_REG) && (dac_nxt == ref_tgt);
    // Fault persists through any retry until regulation is regained or the supervisor drops en.
    fault_nxt   = fault;
    if (nxt_state == S_FAULT)                           fault_nxt = 1'b1;
    else if (nxt_state == S_IDLE || nxt_state == S_REG) fault_nxt = 1'b0;
  end

  always_ff @(posedge CELCLK) begin
    if (!CELRSTN) begin
      cur_state <= S_IDLE;
      cnt       <= '0;
      step_cnt  <= '0;
      pg_cnt    <= '0;
      prechg    <= 1'b0;
      loop_en   <= 1'b0;
      ref_dac   <= '0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
      step_cnt  <= step_nxt;
      pg_cnt    <= pg_nxt;
      prechg    <= prechg_nxt;
      loop_en   <= loop_en_nxt;
      ref_dac   <= dac_nxt;
      ready     <= ready_nxt;
      fault     <= fault_nxt;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_loop_control_sequencer.sv
// Directed bench for loop_control_sequencer: expected output snapshots are queued as stimulus is applied
// and compared one per clock edge against the DUT outputs.
module tb_loop_control_sequencer;
  localparam int REF_W = 8;
  localparam int PRECHG_CYC = 16;
  localparam int STEP_CYC = 4;
`ifdef LOOP_SEQ_RETRY_EN
  localparam int RETRY_CYC = 255;
`endif

  localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, RAMP = 3'd2, REG = 3'd3, FLT = 3'd4, COOL = 3'd5;

  logic             CELCLK = 1'b0;
  logic             CELRSTN;
  logic             en;
  logic [REF_W-1:0] ref_tgt;
  logic             ovp;
  logic             pgood;
  logic             prechg;
  logic             loop_en;
  logic [REF_W-1:0] ref_dac;
  logic             ready;
  logic             fault;
  logic [2:0]       state;

  typedef struct {
    string       tag;
    logic [14:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 CELCLK = ~CELCLK;

  loop_control_sequencer dut (
    .CELCLK (CELCLK),
    .CELRSTN(CELRSTN),
    .en     (en),
    .ref_tgt(ref_tgt),
    .ovp    (ovp),
    .pgood  (pgood),
    .prechg (prechg),
    .loop_en(loop_en),
    .ref_dac(ref_dac),
    .ready  (ready),
    .fault  (fault),
    .state  (state)
  );

  // Packed as {state, prechg, loop_en, fault, ready, ref_dac}
  task automatic expect_n(input string tag, input int n, input logic [2:0] st, input logic pc,
                          input logic le, input logic ft, input logic rd, input logic [REF_W-1:0] dac);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag;
      e.val = {st, pc, le, ft, rd, dac};
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    exp_t        e;
    logic [14:0] obs;
    while (sb.size() > 0) begin
      @(posedge CELCLK);
      #1;
      e   = sb.pop_front();
      obs = {state, prechg, loop_en, fault, ready, ref_dac};
      checks++;
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    CELRSTN = 1'b0;
    en      = 1'b1;
    ref_tgt = 8'd5;
    ovp     = 1'b0;
    pgood   = 1'b1;

    // Reset held with en=1
    expect_n("reset", 2, IDLE, 0, 0, 0, 0, 8'd0);
    drain();

    // Release, precharge, ramp 0..5, regulate
    CELRSTN = 1'b1;
    expect_n("prechg", PRECHG_CYC, PRE, 1, 0, 0, 0, 8'd0);
    for (int k = 0; k < 5; k++) expect_n("ramp", STEP_CYC, RAMP, 0, 1, 0, 0, REF_W'(k));
    expect_n("ramp_top", 1, RAMP, 0, 1, 0, 0, 8'd5);
    expect_n("reg_ready", 3, REG, 0, 1, 0, 1, 8'd5);
    drain();

    // Target down 5 -> 2 in regulation
    ref_tgt = 8'd2;
    expect_n("down_wait", STEP_CYC - 1, REG, 0, 1, 0, 0, 8'd5);
    expect_n("down_4", STEP_CYC, REG, 0, 1, 0, 0, 8'd4);
    expect_n("down_3", STEP_CYC, REG, 0, 1, 0, 0, 8'd3);
    expect_n("down_done", 2, REG, 0, 1, 0, 1, 8'd2);
    drain();

    // Target up 2 -> 3
    ref_tgt = 8'd3;
    expect_n("up_wait", STEP_CYC - 1, REG, 0, 1, 0, 0, 8'd2);
    expect_n("up_done", 2, REG, 0, 1, 0, 1, 8'd3);
    drain();

    // Power-good filter: 2 low cycles tolerated, 3 faults
    pgood = 1'b0;
    expect_n("pg_short", 2, REG, 0, 1, 0, 1, 8'd3);
    drain();
    pgood = 1'b1;
    expect_n("pg_recover", 2, REG, 0, 1, 0, 1, 8'd3);
    drain();
    pgood = 1'b0;
    expect_n("pg_long", 2, REG, 0, 1, 0, 1, 8'd3);
    expect_n("pg_fault", 1, FLT, 0, 0, 1, 0, 8'd0);
    drain();
    pgood = 1'b1;
`ifdef LOOP_SEQ_RETRY_EN
    expect_n("pg_cool", 3, COOL, 0, 0, 1, 0, 8'd0);
`else
    expect_n("pg_fault_hold", 3, FLT, 0, 0, 1, 0, 8'd0);
`endif
    drain();
    en = 1'b0;
    expect_n("pg_clear", 2, IDLE, 0, 0, 0, 0, 8'd0);
    drain();

    // OVP during ramp
    en = 1'b1;
    ref_tgt = 8'd5;
    expect_n("ovp_prechg", PRECHG_CYC, PRE, 1, 0, 0, 0, 8'd0);
    expect_n("ovp_ramp0", STEP_CYC, RAMP, 0, 1, 0, 0, 8'd0);
    expect_n("ovp_ramp1", 2, RAMP, 0, 1, 0, 0, 8'd1);
    drain();
    ovp = 1'b1;
    expect_n("ovp_fault", 1, FLT, 0, 0, 1, 0, 8'd0);
    drain();
    ovp = 1'b0;
`ifdef LOOP_SEQ_RETRY_EN
    expect_n("ovp_cool", RETRY_CYC, COOL, 0, 0, 1, 0, 8'd0);
    expect_n("ovp_retry", 1, PRE, 1, 0, 1, 0, 8'd0);
`else
    expect_n("ovp_hold", 5, FLT, 0, 0, 1, 0, 8'd0);
`endif
    drain();
    en = 1'b0;
    expect_n("ovp_clear", 1, IDLE, 0, 0, 0, 0, 8'd0);
    drain();

    // en drop during precharge
    en = 1'b1;
    expect_n("en_prechg", 2, PRE, 1, 0, 0, 0, 8'd0);
    drain();
    en = 1'b0;
    expect_n("en_abort", 1, IDLE, 0, 0, 0, 0, 8'd0);
    drain();

    // Mid-sequence reset
    en = 1'b1;
    ref_tgt = 8'd0;
    expect_n("rst_prechg", 3, PRE, 1, 0, 0, 0, 8'd0);
    drain();
    CELRSTN = 1'b0;
    expect_n("rst_abort", 1, IDLE, 0, 0, 0, 0, 8'd0);
    drain();
    CELRSTN = 1'b1;

    // ref_tgt=0 enters regulation right after ramp entry, then ovp and en=0 together
    expect_n("z_prechg", PRECHG_CYC, PRE, 1, 0, 0, 0, 8'd0);
    expect_n("z_ramp", 1, RAMP, 0, 1, 0, 0, 8'd0);
    expect_n("z_reg", 2, REG, 0, 1, 0, 1, 8'd0);
    drain();
    ovp = 1'b1;
    en  = 1'b0;
    expect_n("prio_fault", 1, FLT, 0, 0, 1, 0, 8'd0);
    drain();
    ovp = 1'b0;
    expect_n("prio_idle", 2, IDLE, 0, 0, 0, 0, 8'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
